// File: rtl/i2s_defs.sv
// Shared I2S definitions: receiver states, channel encoding and default word/slot geometry
// (the transmitter uses the same defaults so both ends agree).
package i2s_defs;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } i2s_state_e;

    localparam logic LR_LEFT = 1'b0;

    localparam int unsigned I2S_DATA_BITS = 16;
    localparam int unsigned I2S_SLOT_BITS = 32;

endpackage

// File: rtl/i2s_sync_edge.sv
// Three-flop synchroniser for an asynchronous clock-like input with a one-cycle rising-edge
// strobe taken from the second and third stages.
module i2s_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/SDAT on the system clock, checks slot framing and
// emits one out_tick per recovered stereo pair once locked.
module i2s_rx
    import i2s_defs::*;
#(
    parameter int unsigned DATA_BITS  = I2S_DATA_BITS,
    parameter int unsigned SLOT_BITS  = I2S_SLOT_BITS,
    parameter int unsigned LOCK_SLOTS = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        sclk,
    input  logic                        lr_clk,
    input  logic                        sdat,
    output logic signed [DATA_BITS-1:0] left_out,
    output logic signed [DATA_BITS-1:0] right_out,
    output logic                        out_tick,
    output logic                        locked,
    output logic                        frame_err
);

    localparam int unsigned CNT_W  = $clog2(SLOT_BITS + 3);
    localparam int unsigned TO_W   = $clog2(TIMEOUT);
    localparam int unsigned GOOD_W = $clog2(LOCK_SLOTS + 1);

    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0]  SLOT_LEN  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]  DATA_LIM  = CNT_W'(DATA_BITS);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_SLOTS);

    logic [1:0] lr_sync_q;
    logic [1:0] sdat_sync_q;
    logic       sclk_rise;

    i2s_sync_edge u_sclk_sync (
        .CLK  (CLK),
        .RST  (RST),
        .din  (sclk),
        .rise (sclk_rise)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            lr_sync_q   <= '0;
            sdat_sync_q <= '0;
        end else begin
            lr_sync_q   <= {lr_sync_q[0], lr_clk};
            sdat_sync_q <= {sdat_sync_q[0], sdat};
        end
    end

    i2s_state_e           state_q, state_d;
    logic                 lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [DATA_BITS-1:0] left_q, left_d;
    logic [DATA_BITS-1:0] right_q, right_d;
    logic                 tick_q, tick_d;
    logic                 ferr_q, ferr_d;

    logic                 lr_s;
    logic                 sdat_s;
    logic                 capture;
    logic                 transition;
    logic                 slot_ok;
    logic [DATA_BITS-1:0] shift_in;
    logic [DATA_BITS-1:0] word;

    assign lr_s       = lr_sync_q[1];
    assign sdat_s     = sdat_sync_q[1];
    assign capture    = bit_cnt_q < DATA_LIM;
    assign transition = sclk_rise && (lr_s != lr_prev_q);
    // The transition edge's own bit closes the slot, so it counts toward the length.
    assign slot_ok    = (bit_cnt_q + CNT_W'(1)) == SLOT_LEN;
    assign shift_in   = {shift_q[DATA_BITS-2:0], sdat_s};
    assign word       = capture ? shift_in : shift_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= HUNT;
            lr_prev_q    <= LR_LEFT;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            good_q       <= '0;
            to_cnt_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
            tick_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lr_prev_q    <= lr_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            good_q       <= good_d;
            to_cnt_q     <= to_cnt_d;
            left_q       <= left_d;
            right_q      <= right_d;
            tick_q       <= tick_d;
            ferr_q       <= ferr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lr_prev_d    = lr_prev_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        good_d       = good_q;
        to_cnt_d     = to_cnt_q;
        left_d       = left_q;
        right_d      = right_q;
        tick_d       = 1'b0;
        ferr_d       = 1'b0;

        if (state_q == HUNT || sclk_rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d     = '0;
            state_d      = HUNT;
            good_d       = '0;
            hold_valid_d = 1'b0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (sclk_rise) begin
            if (capture) begin
                shift_d = shift_in;
            end
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end

            if (transition) begin
                bit_cnt_d = '0;
                lr_prev_d = lr_s;
                unique case (state_q)
                    HUNT: begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                    SYNC: begin
                        if (!slot_ok) begin
                            good_d = '0;
                            ferr_d = 1'b1;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_d == GOOD_LOCK) begin
                                state_d      = LOCKED;
                                hold_valid_d = 1'b0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!slot_ok) begin
                            ferr_d       = 1'b1;
                            state_d      = SYNC;
                            good_d       = '0;
                            hold_valid_d = 1'b0;
                        end else if (lr_prev_q == LR_LEFT) begin
                            hold_d       = word;
                            hold_valid_d = 1'b1;
                        end else begin
                            // A right slot only completes a pair whose left half was
                            // captured while locked.
                            if (hold_valid_q) begin
                                left_d  = hold_q;
                                right_d = word;
                                tick_d  = 1'b1;
                            end
                            hold_valid_d = 1'b0;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end
    end

    assign left_out  = left_q;
    assign right_out = right_q;
    assign out_tick  = tick_q;
    assign frame_err = ferr_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: an I2S transmitter model drives the pins, expected stereo pairs are
// queued per frame and compared whenever out_tick fires.
module tb_i2s_rx;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               sclk = 1'b0;
    logic               lr_clk = 1'b0;
    logic               sdat = 1'b0;
    logic signed [15:0] left_out;
    logic signed [15:0] right_out;
    logic               out_tick;
    logic               locked;
    logic               frame_err;

    i2s_rx dut (
        .CLK       (CLK),
        .RST       (RST),
        .sclk      (sclk),
        .lr_clk    (lr_clk),
        .sdat      (sdat),
        .left_out  (left_out),
        .right_out (right_out),
        .out_tick  (out_tick),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          trans_cyc = 0;
    int          n_ferr = 0;
    int          ferr0 = 0;
    int          lat = 0;
    logic [31:0] pair;
    logic [31:0] exp_q[$];
    logic        prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (!RST) begin
            if (frame_err) n_ferr++;
            if (out_tick) begin
                if (exp_q.size() == 0) begin
                    check("tick_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    pair = exp_q.pop_front();
                    lat  = cyc - trans_cyc;
                    check("left_out", {16'd0, left_out}, {16'd0, pair[31:16]});
                    check("right_out", {16'd0, right_out}, {16'd0, pair[15:0]});
                    check("latency_le5", 32'(lat <= 5), 32'd1);
                end
            end
        end
    end

    function automatic logic slot_bit(input logic [15:0] w, input int j);
        if (j < 16) return w[15-j];
        return 1'b1;  // padding ones must never reach the captured word
    endfunction

    task automatic tx_period(input logic lr, input logic d, input logic first);
        lr_clk = lr;
        sdat   = d;
        sclk   = 1'b0;
        #40;
        sclk = 1'b1;
        if (first) trans_cyc = cyc;
        #40;
    endtask

    task automatic tx_slot(input logic ch, input logic [15:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            tx_period(ch, (k == 0) ? prev_last : slot_bit(w, k - 1), k == 0);
        end
        prev_last = slot_bit(w, nbits - 1);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                              input int rbits, input logic expect_tick);
        if (expect_tick) exp_q.push_back({l, r});
        tx_slot(1'b0, l, lbits);
        tx_slot(1'b1, r, rbits);
    endtask

    task automatic flush();
        tx_period(1'b0, prev_last, 1'b1);
        tx_period(1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic align();
        @(negedge CLK);
        #3;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_left"}, {16'd0, left_out}, 32'd0);
        check({tag, "_right"}, {16'd0, right_out}, 32'd0);
        check({tag, "_tick"}, 32'(out_tick), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        repeat (4) @(posedge CLK);
        #1;
        check_zero("reset");
        @(negedge CLK);
        RST = 1'b0;
        align();

        // Initial lock on a clean loopback stream
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        check("locked_before_4", 32'(locked), 32'd0);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        check("locked_after_4", 32'(locked), 32'd1);
        for (int i = 0; i < 4; i++) send_frame(16'h1234, 16'hABCD, 32, 32, 1'b1);
        send_frame(16'h8000, 16'h7FFF, 32, 32, 1'b1);
        send_frame(16'hFFFF, 16'h0001, 32, 32, 1'b1);
        check("ferr_none", 32'(n_ferr), 32'd0);

        // One short left slot while locked
        ferr0 = n_ferr;
        send_frame(16'h1111, 16'h2222, 31, 32, 1'b0);
        check("ferr_short_slot", 32'(n_ferr - ferr0), 32'd1);
        check("locked_drop", 32'(locked), 32'd0);
        send_frame(16'h3333, 16'h4444, 32, 32, 1'b0);
        check("relock_wait", 32'(locked), 32'd0);
        send_frame(16'h5555, 16'h6666, 32, 32, 1'b0);
        check("relock", 32'(locked), 32'd1);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b1);
        send_frame(16'h8000, 16'h7FFF, 32, 32, 1'b1);

        // SCLK stops while locked
        send_frame(16'h0F0F, 16'hF0F0, 32, 32, 1'b0);
        check("queue_before_stop", 32'(exp_q.size()), 32'd0);
        repeat (990) @(posedge CLK);
        #1;
        check("locked_before_timeout", 32'(locked), 32'd1);
        repeat (110) @(posedge CLK);
        #1;
        check("locked_after_timeout", 32'(locked), 32'd0);
        align();
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b0);
        send_frame(16'h8000, 16'h7FFF, 32, 32, 1'b1);
        send_frame(16'hFFFF, 16'h0001, 32, 32, 1'b1);

        // Reset in the middle of a right slot
        ferr0 = n_ferr;
        fork
            send_frame(16'h7777, 16'h8888, 32, 32, 1'b0);
            begin
                #(80 * 48 + 20);
                @(negedge CLK);
                RST = 1'b1;
                @(posedge CLK);
                #1;
                check_zero("mid_reset");
                check("queue_at_reset", 32'(exp_q.size()), 32'd0);
                repeat (3) @(negedge CLK);
                RST = 1'b0;
            end
        join
        send_frame(16'h9999, 16'hAAAA, 32, 32, 1'b0);
        check("ferr_partial_slot", 32'(n_ferr - ferr0), 32'd1);
        send_frame(16'hBBBB, 16'hCCCC, 32, 32, 1'b0);
        check("reset_relock_wait", 32'(locked), 32'd0);
        send_frame(16'h5A5A, 16'hC3C3, 32, 32, 1'b1);
        check("reset_relock", 32'(locked), 32'd1);
        send_frame(16'h1234, 16'hABCD, 32, 32, 1'b1);
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: the inbound counterpart of the existing i2s audio transmitter.
- Oversamples external SCLK/LRCLK/SDAT on the 100 MHz system clock and recovers 16-bit signed left/right words.
- Emits one-cycle out_tick per stereo pair, so it drops into the same tick-driven sample path as the cic/deemph/aud_cic chain (e.g. external ADC or loopback of the transmitter for self-test).

Parameters:
- DATA_BITS, 16, bits captured per channel (MSB-first, first DATA_BITS bits of slot).
- SLOT_BITS, 32, expected SCLK periods per channel slot; must be >= DATA_BITS.
- LOCK_SLOTS, 4, consecutive correct-length slots required to declare lock.
- TIMEOUT, 1024, CLK cycles without an SCLK rising edge before returning to HUNT.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST  in  1  synchronous, active-high reset.
- sclk  in  1  I2S bit clock, asynchronous to CLK; high and low phases each >= 4 CLK cycles.
- lr_clk  in  1  I2S word select, async; 0 = left, 1 = right.
- sdat  in  1  I2S serial data, async.
- left_out  out  DATA_BITS  signed left sample, valid with out_tick.
- right_out  out  DATA_BITS  signed right sample, valid with out_tick.
- out_tick  out  1  one-CLK pulse: new stereo pair on left_out/right_out.
- locked  out  1  high while in LOCKED state.
- frame_err  out  1  one-CLK pulse: slot length != SLOT_BITS while SYNC or LOCKED.

Behaviour:
- Reset: state=HUNT; left_out=0, right_out=0, out_tick=0, locked=0, frame_err=0; bit count, shift regs, hold reg, good-slot count, timeout counter all 0. RST wins over every other event, including mid-slot.
- Input conditioning:
  - sclk, lr_clk and sdat each pass through two sync flops; sclk has a third flop for edge detection.
  - Rising edge (rise) = sync2 & ~sync3, one CLK wide.
  - lr and sdat are sampled from sync2 in the rise cycle.
- Bit timing (standard I2S one-bit delay):
  - A rise where sampled lr != lr_prev is a transition edge. Its sdat bit is the LSB of the slot being closed (channel lr_prev).
  - The next rise carries the MSB of the new slot.
- Per rise:
  - Shift sdat into shift reg only while bit_cnt < DATA_BITS.
  - bit_cnt increments, saturating at SLOT_BITS+1.
  - On a transition edge, the closing slot's length is bit_cnt+1 (that edge's bit included). Then bit_cnt resets to 0 and lr_prev updates.
  - Slot OK iff length == SLOT_BITS.
- States:
  - HUNT: ignore data. First transition edge -> SYNC, with bit_cnt cleared and good count = 0.
  - SYNC: at each slot close, an OK slot increments good count and a bad slot zeroes it and pulses frame_err. Good count reaching LOCK_SLOTS -> LOCKED.
  - LOCKED: locked=1.
    - Left slot close (lr_prev=0) OK: captured word -> hold reg.
    - Right slot close OK: right_out <= word, left_out <= hold, out_tick=1 on the CLK cycle after the rise cycle.
    - Bad slot: pulse frame_err, no tick, go to SYNC with good count 0.
  - Any state except HUNT: timeout counter reaches TIMEOUT-1 with no rise -> HUNT, locked=0. The counter clears on every rise.
- The first right slot after entering LOCKED emits a tick only if its preceding left slot was captured while LOCKED. Otherwise that pair is dropped.
- Latency: pin edge -> out_tick <= 5 CLK cycles (3 sync/edge plus 1 capture plus 1 output register).
- left_out/right_out hold their value between ticks. Words are raw two's complement; no rounding or sign manipulation.
- Short slots (< DATA_BITS) are framing errors. Capture contents are discarded.

Decomposition:
- Shared package/header i2s_defs:
  - state encodings HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2;
  - LR_LEFT=1'b0;
  - default DATA_BITS/SLOT_BITS, shared with the transmitter so both ends agree.
- Sub-module i2s_sync_edge: 3-flop synchroniser plus rise detect. Instantiated once for sclk; plain 2-flop syncs for lr_clk/sdat live in i2s_rx.

Test Plan:
- Loopback from audio transmitter model, SLOT_BITS=32, left=16'h1234, right=16'hABCD repeated:
  - locked rises after 4 good slots.
  - Every subsequent out_tick shows left_out=16'h1234, right_out=16'hABCD.
  - Exactly 1 tick per frame.
- Boundary values left=16'h8000, right=16'h7FFF, then left=16'hFFFF, right=16'h0001 -> outputs bit-exact, sign preserved.
- Inject one 31-bit slot while LOCKED:
  - frame_err pulses once, locked drops, no tick for that frame.
  - locked returns after 4 good slots.
- Stop sclk for 1100 CLK cycles while LOCKED -> locked=0 by cycle 1024 after the last rise. Resuming a clean stream relocks.
- Assert RST mid right slot -> all outputs 0 next cycle, state HUNT. After release, no tick until relock; the first tick carries a complete, correct pair.
- Pin-level timing with sclk = CLK/8: measure the LRCLK-closing rise at the pin to out_tick -> <= 5 CLK cycles.
